// File: rtl/maindec_pkg.sv
// Shared types and encodings for the multicycle LEGv8 main decoder.
// The optional unconditional-branch opcode class is used when MAINDEC_B_EN is defined.
package maindec_pkg;

  typedef enum logic [3:0] {
    FETCH,
    DECODE,
    MEMADR,
    MEMRD,
    MEMWB,
    MEMWR,
    EXEC,
    ALUWB,
    CBZ,
    BR,
    HALT
  } state_t;

  typedef enum logic [2:0] {
    OC_LDUR,
    OC_STUR,
    OC_CBZ,
    OC_RTYPE,
    OC_B,
    OC_ILL
  } opclass_t;

  localparam logic [10:0] OP_LDUR    = 11'b11111000010;
  localparam logic [10:0] OP_STUR    = 11'b11111000000;
  localparam logic [10:0] OP_ADD     = 11'b10001011000;
  localparam logic [10:0] OP_SUB     = 11'b11001011000;
  localparam logic [10:0] OP_AND     = 11'b10001010000;
  localparam logic [10:0] OP_ORR     = 11'b10101010000;
  // Prefix-matched opcodes: CBZ on Op[10:3], B on Op[10:5]
  localparam logic [7:0]  OP_CBZ_PFX = 8'b10110100;
  localparam logic [5:0]  OP_B_PFX   = 6'b000101;

  localparam logic [1:0] SRCB_REG     = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_PASSB = 2'b01;
  localparam logic [1:0] ALUOP_RTYPE = 2'b10;

endpackage

// File: rtl/maindec_opclass.sv
// Combinational opcode classifier for the multicycle main decoder.
// Unconditional branch B is recognised only when MAINDEC_B_EN is defined.
module maindec_opclass
  import maindec_pkg::*;
#(
  parameter int unsigned OPW = 11
) (
  input  logic [OPW-1:0] Op,
  output opclass_t       opclass
);

  always_comb begin
    opclass = OC_ILL;
    if (Op == OP_LDUR) begin
      opclass = OC_LDUR;
    end else if (Op == OP_STUR) begin
      opclass = OC_STUR;
    end else if (Op[10:3] == OP_CBZ_PFX) begin
      opclass = OC_CBZ;
    end else if ((Op == OP_ADD) || (Op == OP_SUB) || (Op == OP_AND) || (Op == OP_ORR)) begin
      opclass = OC_RTYPE;
    end
`ifdef MAINDEC_B_EN
    else if (Op[10:5] == OP_B_PFX) begin
      opclass = OC_B;
    end
`endif
  end

endmodule

// File: rtl/maindec_fsm.sv
// Multicycle LEGv8 main decoder: Moore FSM with memory-ready stalls.
// Define MAINDEC_B_EN to add the unconditional branch (B) sequence.
module maindec_fsm
  import maindec_pkg::*;
#(
  parameter int unsigned OPW    = 11,
  parameter int unsigned ALUOPW = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [OPW-1:0]    Op,
  input  logic              mem_ready,
  output logic              PCWrite,
  output logic              IRWrite,
  output logic              Reg2Loc,
  output logic              ALUSrcA,
  output logic [1:0]        ALUSrcB,
  output logic              MemtoReg,
  output logic              RegWrite,
  output logic              MemRead,
  output logic              MemWrite,
  output logic              Branch,
  output logic [ALUOPW-1:0] ALUOp,
  output logic              instr_done,
  output logic              illegal
);

  state_t   r_state;
  opclass_t w_opclass;

  maindec_opclass #(
    .OPW (OPW)
  ) u_opclass (
    .Op      (Op),
    .opclass (w_opclass)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= FETCH;
    end else begin
      unique case (r_state)
        FETCH:  if (mem_ready) r_state <= DECODE;
        DECODE: begin
          unique case (w_opclass)
            OC_LDUR, OC_STUR: r_state <= MEMADR;
            OC_CBZ:           r_state <= CBZ;
            OC_RTYPE:         r_state <= EXEC;
            OC_B:             r_state <= BR;
            default:          r_state <= HALT;
          endcase
        end
        MEMADR: r_state <= (w_opclass == OC_LDUR) ? MEMRD : MEMWR;
        MEMRD:  if (mem_ready) r_state <= MEMWB;
        MEMWR:  if (mem_ready) r_state <= FETCH;
        EXEC:   r_state <= ALUWB;
        MEMWB, ALUWB, CBZ, BR: r_state <= FETCH;
        HALT:   r_state <= HALT;
        default: r_state <= FETCH;
      endcase
    end
  end

  always_comb begin
    PCWrite    = 1'b0;
    IRWrite    = 1'b0;
    Reg2Loc    = 1'b0;
    ALUSrcA    = 1'b0;
    ALUSrcB    = SRCB_REG;
    MemtoReg   = 1'b0;
    RegWrite   = 1'b0;
    MemRead    = 1'b0;
    MemWrite   = 1'b0;
    Branch     = 1'b0;
    ALUOp      = ALUOPW'(ALUOP_ADD);
    instr_done = 1'b0;
    illegal    = 1'b0;
    unique case (r_state)
      FETCH: begin
        MemRead = 1'b1;
        ALUSrcB = SRCB_FOUR;
        PCWrite = mem_ready;
        IRWrite = mem_ready;
      end
      DECODE: begin
        ALUSrcB = SRCB_IMM_SH2;
        Reg2Loc = (w_opclass == OC_STUR) || (w_opclass == OC_CBZ);
      end
      MEMADR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = SRCB_IMM;
      end
      MEMRD: begin
        MemRead = 1'b1;
        ALUSrcA = 1'b1;
        ALUSrcB = SRCB_IMM;
      end
      MEMWB: begin
        RegWrite   = 1'b1;
        MemtoReg   = 1'b1;
        instr_done = 1'b1;
      end
      MEMWR: begin
        MemWrite   = 1'b1;
        Reg2Loc    = 1'b1;
        ALUSrcA    = 1'b1;
        ALUSrcB    = SRCB_IMM;
        instr_done = mem_ready;
      end
      EXEC: begin
        ALUSrcA = 1'b1;
        ALUOp   = ALUOPW'(ALUOP_RTYPE);
      end
      ALUWB: begin
        RegWrite   = 1'b1;
        ALUOp      = ALUOPW'(ALUOP_RTYPE);
        instr_done = 1'b1;
      end
      CBZ: begin
        ALUSrcA    = 1'b1;
        ALUOp      = ALUOPW'(ALUOP_PASSB);
        Reg2Loc    = 1'b1;
        Branch     = 1'b1;
        instr_done = 1'b1;
      end
      BR: begin
        PCWrite    = 1'b1;
        ALUSrcB    = SRCB_IMM_SH2;
        instr_done = 1'b1;
      end
      HALT: illegal = 1'b1;
      default: ;
    endcase
    // Held reset aborts any in-flight instruction: no writes, no completion pulse
    if (!reset) begin
      PCWrite    = 1'b0;
      IRWrite    = 1'b0;
      Reg2Loc    = 1'b0;
      ALUSrcA    = 1'b0;
      ALUSrcB    = SRCB_REG;
      MemtoReg   = 1'b0;
      RegWrite   = 1'b0;
      MemRead    = 1'b0;
      MemWrite   = 1'b0;
      Branch     = 1'b0;
      ALUOp      = '0;
      instr_done = 1'b0;
      illegal    = 1'b0;
    end
  end

endmodule

// File: tb/tb_maindec_fsm.sv
// Directed self-checking bench for maindec_fsm; outputs packed into one vector per cycle.
// Build with MAINDEC_B_EN defined to exercise the unconditional-branch path.
module tb_maindec_fsm;

  logic        clk = 1'b0;
  logic        reset;
  logic [10:0] Op;
  logic        mem_ready;
  logic        PCWrite, IRWrite, Reg2Loc, ALUSrcA, MemtoReg, RegWrite;
  logic        MemRead, MemWrite, Branch, instr_done, illegal;
  logic [1:0]  ALUSrcB, ALUOp;

  int unsigned n_checks = 0;
  int unsigned n_fails  = 0;

  always #5 clk = ~clk;

  maindec_fsm u_dut (
    .clk        (clk),
    .reset      (reset),
    .Op         (Op),
    .mem_ready  (mem_ready),
    .PCWrite    (PCWrite),
    .IRWrite    (IRWrite),
    .Reg2Loc    (Reg2Loc),
    .ALUSrcA    (ALUSrcA),
    .ALUSrcB    (ALUSrcB),
    .MemtoReg   (MemtoReg),
    .RegWrite   (RegWrite),
    .MemRead    (MemRead),
    .MemWrite   (MemWrite),
    .Branch     (Branch),
    .ALUOp      (ALUOp),
    .instr_done (instr_done),
    .illegal    (illegal)
  );

  // {PCWrite,IRWrite,Reg2Loc,ALUSrcA,ALUSrcB[1:0],MemtoReg,RegWrite,
  //  MemRead,MemWrite,Branch,ALUOp[1:0],instr_done,illegal}
  logic [14:0] outs;
  assign outs = {PCWrite, IRWrite, Reg2Loc, ALUSrcA, ALUSrcB, MemtoReg, RegWrite,
                 MemRead, MemWrite, Branch, ALUOp, instr_done, illegal};

  localparam logic [14:0] E_ZERO    = 15'b0_0_0_0_00_0_0_0_0_0_00_0_0;
  localparam logic [14:0] E_FETCH   = 15'b1_1_0_0_01_0_0_1_0_0_00_0_0;
  localparam logic [14:0] E_FETCHW  = 15'b0_0_0_0_01_0_0_1_0_0_00_0_0;
  localparam logic [14:0] E_DEC     = 15'b0_0_0_0_11_0_0_0_0_0_00_0_0;
  localparam logic [14:0] E_DEC_R2L = 15'b0_0_1_0_11_0_0_0_0_0_00_0_0;
  localparam logic [14:0] E_MEMADR  = 15'b0_0_0_1_10_0_0_0_0_0_00_0_0;
  localparam logic [14:0] E_MEMRD   = 15'b0_0_0_1_10_0_0_1_0_0_00_0_0;
  localparam logic [14:0] E_MEMWB   = 15'b0_0_0_0_00_1_1_0_0_0_00_1_0;
  localparam logic [14:0] E_MEMWR   = 15'b0_0_1_1_10_0_0_0_1_0_00_1_0;
  localparam logic [14:0] E_MEMWRW  = 15'b0_0_1_1_10_0_0_0_1_0_00_0_0;
  localparam logic [14:0] E_EXEC    = 15'b0_0_0_1_00_0_0_0_0_0_10_0_0;
  localparam logic [14:0] E_ALUWB   = 15'b0_0_0_0_00_0_1_0_0_0_10_1_0;
  localparam logic [14:0] E_CBZ     = 15'b0_0_1_1_00_0_0_0_0_1_01_1_0;
  localparam logic [14:0] E_HALT    = 15'b0_0_0_0_00_0_0_0_0_0_00_0_1;
  localparam logic [14:0] E_BR      = 15'b1_0_0_0_11_0_0_0_0_0_00_1_0;

  localparam logic [10:0] LDUR = 11'b11111000010;
  localparam logic [10:0] STUR = 11'b11111000000;
  localparam logic [10:0] CBZ  = 11'b10110100000;
  localparam logic [10:0] ADD  = 11'b10001011000;
  localparam logic [10:0] ORR  = 11'b10101010000;
  localparam logic [10:0] BOP  = 11'b00010100000;

  task automatic check(input string tag, input logic [14:0] got, input logic [14:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got %b expected %b", tag, got, exp);
    end
  endtask

  // Called at posedge+1: let combinational outputs settle, compare, advance one cycle
  task automatic cyc(input string tag, input logic [14:0] exp);
    #1;
    check(tag, outs, exp);
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset     = 1'b0;
    Op        = LDUR;
    mem_ready = 1'b1;
    @(posedge clk);
    #1;
    cyc("reset_c1", E_ZERO);
    cyc("reset_c2", E_ZERO);

    // LDUR, zero wait states
    reset = 1'b1;
    cyc("ldur_fetch", E_FETCH);
    cyc("ldur_decode", E_DEC);
    cyc("ldur_memadr", E_MEMADR);
    cyc("ldur_memrd", E_MEMRD);
    cyc("ldur_memwb", E_MEMWB);

    // STUR with three wait states in MEMWR
    Op = STUR;
    cyc("stur_fetch", E_FETCH);
    cyc("stur_decode", E_DEC_R2L);
    cyc("stur_memadr", E_MEMADR);
    mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) cyc("stur_memwr_wait", E_MEMWRW);
    mem_ready = 1'b1;
    cyc("stur_memwr_done", E_MEMWR);

    // CBZ then ADD back-to-back
    Op = CBZ;
    cyc("cbz_fetch", E_FETCH);
    cyc("cbz_decode", E_DEC_R2L);
    cyc("cbz_exec", E_CBZ);
    Op = ADD;
    cyc("add_fetch", E_FETCH);
    cyc("add_decode", E_DEC);
    cyc("add_exec", E_EXEC);
    cyc("add_aluwb", E_ALUWB);

    // ORR with a fetch wait state and a LDUR read wait state
    Op = ORR;
    mem_ready = 1'b0;
    cyc("orr_fetch_wait", E_FETCHW);
    mem_ready = 1'b1;
    cyc("orr_fetch", E_FETCH);
    mem_ready = 1'b0;
    cyc("orr_decode", E_DEC);
    cyc("orr_exec", E_EXEC);
    cyc("orr_aluwb", E_ALUWB);
    Op = LDUR;
    mem_ready = 1'b1;
    cyc("ldur2_fetch", E_FETCH);
    cyc("ldur2_decode", E_DEC);
    cyc("ldur2_memadr", E_MEMADR);
    mem_ready = 1'b0;
    cyc("ldur2_memrd_wait", E_MEMRD);
    mem_ready = 1'b1;
    cyc("ldur2_memrd", E_MEMRD);
    cyc("ldur2_memwb", E_MEMWB);

    // Reset in the STUR write cycle aborts it
    Op = STUR;
    cyc("abort_fetch", E_FETCH);
    cyc("abort_decode", E_DEC_R2L);
    cyc("abort_memadr", E_MEMADR);
    reset = 1'b0;
    cyc("abort_rst", E_ZERO);
    reset = 1'b1;
    cyc("abort_refetch", E_FETCH);

    // Illegal opcode: sticky HALT until reset
    Op = 11'b00000000000;
    cyc("ill_decode", E_DEC);
    for (int i = 0; i < 10; i++) begin
      mem_ready = i[0];
      cyc("ill_halt", E_HALT);
    end
    reset = 1'b0;
    cyc("ill_rst", E_ZERO);
    reset = 1'b1;
    mem_ready = 1'b1;
    cyc("ill_refetch", E_FETCH);

    // Unconditional branch
    Op = BOP;
    cyc("b_decode", E_DEC);
`ifdef MAINDEC_B_EN
    cyc("b_br", E_BR);
    Op = CBZ;
    cyc("b_fetch", E_FETCH);
`else
    cyc("b_halt", E_HALT);
    cyc("b_halt2", E_HALT);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fails);
    $finish;
  end

  // Every cycle: no simultaneous read/write, no register write alongside a store
  always @(negedge clk) begin
    if (reset === 1'b1) begin
      check("excl_rd_wr", {13'b0, MemRead & MemWrite, RegWrite & MemWrite}, E_ZERO);
    end
  end

endmodule

// File: doc/maindec_fsm.md
Name: maindec_fsm

Overview:
- Multicycle successor to the single-cycle LEGv8 main decoder.
- Same opcode set, same control-signal vocabulary, plus multicycle datapath controls: PC/IR write enables and a 2-bit ALU B-source.
- Sequences each instruction through a Moore FSM and stalls on a memory ready handshake.
- Sits between the instruction register and the shared multicycle datapath; feeds alucontrol via ALUOp.

Parameters:
- OPW, 11, opcode field width (instr[31:21]).
- ALUOPW, 2, ALUOp width.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-low reset.
- Op  in  OPW  opcode from instruction register; stable from DECODE until instruction end.
- mem_ready  in  1  memory completes current read/write this cycle.
- PCWrite  out  1  load PC.
- IRWrite  out  1  load instruction register.
- Reg2Loc  out  1  register-file read-address-2 select (1 = Rt).
- ALUSrcA  out  1  0 = PC, 1 = register A.
- ALUSrcB  out  2  00 = register B, 01 = constant 4, 10 = sign-extended imm, 11 = imm<<2.
- MemtoReg  out  1  write-back from memory data.
- RegWrite  out  1  register-file write.
- MemRead  out  1  memory read request.
- MemWrite  out  1  memory write request.
- Branch  out  1  conditional branch qualify (datapath ANDs with zero).
- ALUOp  out  ALUOPW  00 add, 01 pass-B/compare, 10 R-type funct.
- instr_done  out  1  one-cycle pulse in the final cycle of each instruction.
- illegal  out  1  sticky unsupported-opcode flag.

Behaviour:
- Reset: while reset==0 at a clock edge, state <= FETCH. During reset low, all outputs are forced to 0. First cycle after release is FETCH.
- Outputs are a combinational decode of the state register. Reg2Loc in DECODE depends on Op. Unlisted outputs are 0.
- FETCH: MemRead=1, ALUSrcA=0, ALUSrcB=01, ALUOp=00.
  - PCWrite=IRWrite=mem_ready.
  - Stay while !mem_ready; go to DECODE on mem_ready.
- DECODE: ALUSrcA=0, ALUSrcB=11, ALUOp=00; Reg2Loc=1 for STUR/CBZ. Next state by opcode:
  - LDUR 11111000010 -> MEMADR
  - STUR 11111000000 -> MEMADR
  - CBZ 10110100xxx -> CBZ
  - ADD 10001011000, SUB 11001011000, AND 10001010000, ORR 10101010000 -> EXEC
  - anything else -> HALT
- MEMADR: ALUSrcA=1, ALUSrcB=10, ALUOp=00. Go to MEMRD if LDUR, else MEMWR.
- MEMRD: MemRead=1, ALUSrcA=1, ALUSrcB=10. Wait for mem_ready, then MEMWB.
- MEMWB: RegWrite=1, MemtoReg=1, instr_done=1 -> FETCH.
- MEMWR: MemWrite=1, Reg2Loc=1, ALUSrcA=1, ALUSrcB=10. instr_done=mem_ready. Go to FETCH on mem_ready.
- EXEC: ALUSrcA=1, ALUSrcB=00, ALUOp=10 -> ALUWB.
- ALUWB: RegWrite=1, ALUOp=10, instr_done=1 -> FETCH.
- CBZ: ALUSrcA=1, ALUSrcB=00, ALUOp=01, Reg2Loc=1, Branch=1, instr_done=1 -> FETCH.
- HALT: illegal=1, all enables 0. Stays until reset.
- Latency with zero wait states (cycles from FETCH entry to return): CBZ 3, R-type 4, STUR 4, LDUR 5. Each mem_ready=0 cycle in FETCH/MEMRD/MEMWR adds one cycle.
- No two of {MemRead, MemWrite} are ever 1 simultaneously. RegWrite is never 1 in the same cycle as MemWrite.
- mem_ready is ignored in non-memory states.
- Reset mid-instruction aborts it: no instr_done pulse, and no write occurs in the reset cycle.

Optional Feature:
- MAINDEC_B_EN: adds unconditional branch B (Op[10:5]==000101).
  - DECODE -> BR state: PCWrite=1, ALUSrcA=0, ALUSrcB=11, ALUOp=00, instr_done=1 -> FETCH. Latency 3.
  - Without the macro, B opcodes go to HALT.

Decomposition:
- maindec_pkg holds:
  - state_t enum (FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXEC, ALUWB, CBZ, BR, HALT)
  - opcode localparams
  - ALUSrcB encodings (SRCB_REG, SRCB_FOUR, SRCB_IMM, SRCB_IMM_SH2)
  - ALUOp encodings
  - opclass_t enum (OC_LDUR, OC_STUR, OC_CBZ, OC_RTYPE, OC_B, OC_ILL)
- Sub-module maindec_opclass: combinational Op -> opclass_t, with the MAINDEC_B_EN guard inside it.

Test Plan:
- Reset low 2 cycles with Op=LDUR and mem_ready=1 -> all outputs 0. After release: FETCH with MemRead=1, PCWrite=IRWrite=1.
- Op=11111000010 (LDUR), mem_ready=1 constantly -> states FETCH, DECODE, MEMADR, MEMRD, MEMWB. instr_done only in cycle 5, with RegWrite=MemtoReg=1.
- Op=11111000000 (STUR), mem_ready=0 for 3 cycles in MEMWR -> MemWrite=1 held 4 cycles. instr_done with the mem_ready pulse. Reg2Loc=1 in DECODE and MEMWR.
- Op=10110100000 (CBZ) then Op=10001011000 (ADD) back-to-back:
  - CBZ: 3 cycles, Branch=1 and ALUOp=01 in cycle 3.
  - ADD: 4 cycles, ALUOp=10 in EXEC and ALUWB, RegWrite only in ALUWB.
- Op=00000000000 -> HALT after DECODE, illegal=1 held 10 cycles. Reset low clears illegal and restarts at FETCH.
- Op=00010100000 -> with MAINDEC_B_EN: PCWrite=1 in cycle 3, then FETCH. Without it: illegal=1.
